// File: rtl/fb_pkg.sv
// fb_pkg: shared framebuffer writer state type, default frame geometry and address-width helper
package fb_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_SOF, WRITE} fb_wr_state_t;
  localparam int FB_W = 160;
  localparam int FB_H = 120;
  localparam int FB_DEPTH = FB_W * FB_H;
  function automatic int fb_addrw(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/fb_stream_writer.sv
// fb_stream_writer: raster pixel stream to registered framebuffer write port; FB_WRITER_ONESHOT_EN adds arm-gated single-frame capture
module fb_stream_writer
  import fb_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = FB_DEPTH,
  localparam int ADDRW = fb_addrw(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  input  logic             s_sof,
`ifdef FB_WRITER_ONESHOT_EN
  input  logic             arm,
`endif
  output logic             s_ready,
  output logic             we,
  output logic [ADDRW-1:0] waddr,
  output logic [WIDTH-1:0] wdata,
  output logic             frame_done,
  output logic             err_short,
  output logic             drop,
  output logic             busy
);
  localparam logic [ADDRW-1:0] LAST = ADDRW'(DEPTH - 1);
`ifdef FB_WRITER_ONESHOT_EN
  localparam fb_wr_state_t RST_STATE = IDLE;
`else
  localparam fb_wr_state_t RST_STATE = WAIT_SOF;
`endif
  localparam fb_wr_state_t DONE_STATE = RST_STATE;
  fb_wr_state_t state_q, state_d;
  logic [ADDRW-1:0] count_q, count_d, waddr_q, waddr_d, addr;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic we_q, we_d, frame_done_q, frame_done_d, err_short_q, err_short_d, drop_q, drop_d;
  logic acc, wr, last;
  assign s_ready = !rst && state_q != IDLE;
  always_comb begin
    acc = s_valid && s_ready;
    wr = acc && (s_sof || state_q == WRITE);
    addr = s_sof ? '0 : count_q;
    last = addr == LAST;
    we_d = wr;
    waddr_d = wr ? addr : waddr_q;
    wdata_d = wr ? s_data : wdata_q;
    frame_done_d = wr && last;
    // an SOF landing exactly where addr 0 was due anyway is not a short frame
    err_short_d = wr && s_sof && state_q == WRITE && count_q != '0;
    drop_d = acc && !s_sof && state_q == WAIT_SOF;
    count_d = wr ? (last ? '0 : addr + ADDRW'(1)) : count_q;
    state_d = wr ? (last ? DONE_STATE : WRITE) : state_q;
`ifdef FB_WRITER_ONESHOT_EN
    if (state_q == IDLE && arm) state_d = WAIT_SOF;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RST_STATE;
      count_q <= '0;
      we_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      frame_done_q <= 1'b0;
      err_short_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      we_q <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      frame_done_q <= frame_done_d;
      err_short_q <= err_short_d;
      drop_q <= drop_d;
    end
  end
  assign we = we_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;
  assign frame_done = frame_done_q;
  assign err_short = err_short_q;
  assign drop = drop_q;
  assign busy = state_q == WRITE;
endmodule

// File: tb/tb_fb_stream_writer.sv
// tb_fb_stream_writer: scoreboard bench for fb_stream_writer at DEPTH=16, WIDTH=1 (covers FB_WRITER_ONESHOT_EN when defined)
module tb_fb_stream_writer;
  localparam int DEPTH = 16;
  localparam int WIDTH = 1;
  localparam int AW = 4;
`ifdef FB_WRITER_ONESHOT_EN
  localparam bit ONESHOT = 1'b1;
  logic arm = 1'b0;
`else
  localparam bit ONESHOT = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, s_valid = 1'b0, s_sof = 1'b0;
  logic [WIDTH-1:0] s_data = '0;
  logic s_ready, we, frame_done, err_short, drop, busy;
  logic [AW-1:0] waddr;
  logic [WIDTH-1:0] wdata;
  typedef struct packed {logic [AW-1:0] a; logic [WIDTH-1:0] d; logic done; logic err;} exp_t;
  exp_t sb[$];
  int total = 0, bad = 0, drop_seen = 0, done_seen = 0, m_pos = -1;
  bit m_armed = !ONESHOT;

  always #5 clk = ~clk;

  fb_stream_writer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_sof(s_sof),
`ifdef FB_WRITER_ONESHOT_EN
    .arm(arm),
`endif
    .s_ready(s_ready), .we(we), .waddr(waddr), .wdata(wdata),
    .frame_done(frame_done), .err_short(err_short), .drop(drop), .busy(busy)
  );

  // monitor: every write must match the oldest predicted write
  always @(negedge clk) begin : mon
    exp_t e;
    if (drop) drop_seen++;
    if (frame_done) done_seen++;
    if (we) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: waddr=%0d wdata=%0d, required no write", waddr, wdata);
      end else begin
        e = sb.pop_front();
        if ({waddr, wdata, frame_done, err_short} !== e) begin
          bad++;
          $display("FAIL write: got addr=%0d data=%0d done=%b err=%b, required addr=%0d data=%0d done=%b err=%b",
                   waddr, wdata, frame_done, err_short, e.a, e.d, e.done, e.err);
        end
      end
    end else if (frame_done || err_short) begin
      total++;
      bad++;
      $display("FAIL pulse_without_write: done=%b err=%b, required 0 0", frame_done, err_short);
    end
  end

  task automatic beat(input logic v, input logic sof, input logic [WIDTH-1:0] d);
    @(negedge clk);
    s_valid = v;
    s_sof = sof;
    s_data = d;
    if (v && m_armed) begin
      if (sof) begin
        sb.push_back({AW'(0), d, 1'b0, 1'(m_pos > 0)});
        m_pos = 1;
      end else if (m_pos >= 0) begin
        sb.push_back({AW'(m_pos), d, 1'(m_pos == DEPTH - 1), 1'b0});
        if (m_pos == DEPTH - 1) begin
          m_pos = -1;
          if (ONESHOT) m_armed = 1'b0;
        end else m_pos++;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      s_valid = 1'b0;
      s_sof = 1'b0;
    end
  endtask

  task automatic arm_pulse();
    idle(1);
`ifdef FB_WRITER_ONESHOT_EN
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    m_armed = 1'b1;
`endif
  endtask

  task automatic frame();
    beat(1'b1, 1'b1, 1'b1);
    for (int i = 1; i < DEPTH; i++) beat(1'b1, 1'b0, WIDTH'(i % 2 == 0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    s_valid = 1'b0;
    s_sof = 1'b0;
    m_pos = -1;
    @(negedge clk);
    rst = 1'b0;
    m_armed = !ONESHOT;
  endtask

  task automatic check_drained(input string tag);
    idle(3);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s_drained: %0d writes missing, required 0", tag, sb.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({we, frame_done, err_short, drop, busy, s_ready} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags: we,done,err,drop,busy,ready=%b required 000000",
               {we, frame_done, err_short, drop, busy, s_ready});
    end
    total++;
    if (waddr !== '0 || wdata !== '0) begin
      bad++;
      $display("FAIL reset_bus: waddr=%0d wdata=%0d required 0 0", waddr, wdata);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (s_ready !== !ONESHOT || busy !== 1'b0) begin
      bad++;
      $display("FAIL post_reset: s_ready=%b busy=%b required %b 0", s_ready, busy, !ONESHOT);
    end
  endtask

  task automatic test_frame();
    int d0;
    arm_pulse();
    d0 = done_seen;
    beat(1'b1, 1'b1, 1'b1);
    beat(1'b1, 1'b0, 1'b0);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_in_frame: busy=%b required 1", busy);
    end
    for (int i = 2; i < DEPTH; i++) beat(1'b1, 1'b0, WIDTH'(i % 2 == 0));
    check_drained("frame");
    total++;
    if (done_seen - d0 !== 1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL frame_end: done pulses=%0d busy=%b required 1 0", done_seen - d0, busy);
    end
  endtask

  task automatic test_drop();
    int d0;
    do_reset();
    arm_pulse();
    d0 = drop_seen;
    repeat (3) beat(1'b1, 1'b0, 1'b1);
    frame();
    check_drained("drop");
    total++;
    if (drop_seen - d0 !== 3) begin
      bad++;
      $display("FAIL drop_count: drops=%0d required 3", drop_seen - d0);
    end
  endtask

  task automatic test_restart();
    int d0;
    arm_pulse();
    d0 = done_seen;
    beat(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) beat(1'b1, 1'b0, 1'b1);
    frame();
    check_drained("restart");
    total++;
    if (done_seen - d0 !== 1) begin
      bad++;
      $display("FAIL restart_done: done pulses=%0d required 1", done_seen - d0);
    end
  endtask

  task automatic test_random_valid();
    int d0, n, cyc;
    logic v;
    arm_pulse();
    d0 = done_seen;
    beat(1'b1, 1'b1, WIDTH'($urandom));
    n = 1;
    cyc = 0;
    while (n < DEPTH && cyc < 400) begin
      v = 1'($urandom_range(0, 1));
      beat(v, 1'b0, WIDTH'($urandom));
      if (v) n++;
      cyc++;
    end
    check_drained("random");
    total++;
    if (n != DEPTH || done_seen - d0 !== 1) begin
      bad++;
      $display("FAIL random_frame: beats=%0d done pulses=%0d required %0d 1", n, done_seen - d0, DEPTH);
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    arm_pulse();
    d0 = done_seen;
    beat(1'b1, 1'b1, 1'b1);
    for (int i = 1; i < 7; i++) beat(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    s_valid = 1'b0;
    m_pos = -1;
    @(negedge clk);
    total++;
    if (we !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: we=%b busy=%b required 0 0", we, busy);
    end
    rst = 1'b0;
    m_armed = !ONESHOT;
    arm_pulse();
    frame();
    check_drained("reset_mid");
    total++;
    if (done_seen - d0 !== 1) begin
      bad++;
      $display("FAIL reset_mid_done: done pulses=%0d required 1", done_seen - d0);
    end
  endtask

  task automatic test_back_to_back();
    int d0;
    arm_pulse();
    d0 = done_seen;
    frame();
    frame();
    check_drained("b2b");
    total++;
    if (done_seen - d0 !== (ONESHOT ? 1 : 2) || s_ready !== !ONESHOT) begin
      bad++;
      $display("FAIL b2b: done pulses=%0d s_ready=%b required %0d %b",
               done_seen - d0, s_ready, ONESHOT ? 1 : 2, !ONESHOT);
    end
  endtask

`ifdef FB_WRITER_ONESHOT_EN
  task automatic test_oneshot();
    int d0;
    do_reset();
    d0 = done_seen;
    frame();
    total++;
    if (s_ready !== 1'b0) begin
      bad++;
      $display("FAIL oneshot_unarmed: s_ready=%b required 0", s_ready);
    end
    frame();
    arm_pulse();
    frame();
    frame();
    check_drained("oneshot");
    total++;
    if (done_seen - d0 !== 1 || s_ready !== 1'b0) begin
      bad++;
      $display("FAIL oneshot: done pulses=%0d s_ready=%b required 1 0", done_seen - d0, s_ready);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_frame();
    test_drop();
    test_restart();
    test_random_valid();
    test_reset_mid();
    test_back_to_back();
`ifdef FB_WRITER_ONESHOT_EN
    test_oneshot();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
